// File: rtl/axis_fifo_arbiter_pkg.sv
// Shared types for the AXI-Stream packet arbiter in front of a FIFO write port.
// Holds the FSM state encoding and the beat-counter sizing rule.
package axis_fifo_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FWD   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   // One extra bit so a count of exactly max_beats is representable.
   function automatic int beat_cnt_width(input int max_beats);
      return $clog2(max_beats) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_arbiter_rr.sv
// Combinational round-robin search: first requester strictly after last_grant,
// wrapping around. last_grant and grant are one-hot.
module rr_arbiter #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0] req,
   input  logic [N_IN-1:0] last_grant,
   output logic [N_IN-1:0] grant
);

   localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

   logic [N_IN-1:0] upper_mask;
   logic [N_IN-1:0] req_upper;
   logic [N_IN-1:0] pick_upper;
   logic [N_IN-1:0] pick_any;

   // upper_mask covers positions above the previous owner; a top-bit owner shifts out to zero.
   assign upper_mask = ~((last_grant << 1) - ONE);
   assign req_upper  = req & upper_mask;
   assign pick_upper = req_upper & (~req_upper + ONE);
   assign pick_any   = req & (~req + ONE);
   assign grant      = (req_upper != '0) ? pick_upper : pick_any;

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Packet-granular round-robin arbiter merging N_IN AXI-Stream requesters into
// one FIFO write port; packets longer than MAX_BEATS are truncated and drained.
module axis_fifo_arbiter
   import axis_fifo_arbiter_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int DATA_WIDTH = 16,
   parameter int USER_WIDTH = 1,
   parameter int MAX_BEATS  = 256
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [N_IN*DATA_WIDTH-1:0] s_axis_in_tdata,
   input  logic [N_IN*USER_WIDTH-1:0] s_axis_in_tuser,
   input  logic [N_IN-1:0]            s_axis_in_tlast,
   input  logic [N_IN-1:0]            s_axis_in_tvalid,
   output logic [N_IN-1:0]            s_axis_in_tready,
   output logic [DATA_WIDTH-1:0]      m_axis_out_tdata,
   output logic [USER_WIDTH-1:0]      m_axis_out_tuser,
   output logic                       m_axis_out_tlast,
   output logic                       m_axis_out_tvalid,
   input  logic                       m_axis_out_tfull,
   output logic [N_IN-1:0]            grant_o,
   output logic                       busy_o,
   output logic                       overlen_o,
   output logic [31:0]                pkt_cnt_o,
   output arb_state_e                 state_o
);

   // Handshake: an input beat moves when tvalid[k] & tready[k] at a rising edge;
   // an output beat is written when m_axis_out_tvalid is high (FIFO has no ready).
   localparam int              CW        = beat_cnt_width(MAX_BEATS);
   localparam int              IW        = $clog2(N_IN);
   localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BEATS - 1);
   localparam logic [N_IN-1:0] LAST_INIT = {1'b1, {(N_IN-1){1'b0}}};

   arb_state_e        state_q;
   logic [N_IN-1:0]   grant_q;
   logic [N_IN-1:0]   last_grant_q;
   logic [IW-1:0]     gidx_q;
   logic [CW-1:0]     beat_cnt_q;
   logic [31:0]       pkt_cnt_q;
   logic              overlen_q;

   logic [N_IN-1:0]       rr_grant;
   logic [IW-1:0]         rr_idx;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [USER_WIDTH-1:0] sel_user;
   logic                  xfer;

   rr_arbiter #(.N_IN(N_IN)) u_rr (
      .req        (s_axis_in_tvalid),
      .last_grant (last_grant_q),
      .grant      (rr_grant)
   );

   always_comb begin
      rr_idx = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (rr_grant[k]) rr_idx = IW'(k);
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_user  = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (gidx_q == IW'(k)) begin
            sel_valid = s_axis_in_tvalid[k];
            sel_last  = s_axis_in_tlast[k];
            sel_data  = s_axis_in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            sel_user  = s_axis_in_tuser[k*USER_WIDTH +: USER_WIDTH];
         end
      end
   end

   always_comb begin
      s_axis_in_tready  = '0;
      m_axis_out_tdata  = '0;
      m_axis_out_tuser  = '0;
      m_axis_out_tlast  = 1'b0;
      m_axis_out_tvalid = 1'b0;
      xfer              = 1'b0;
      case (state_q)
         ST_FWD: begin
            s_axis_in_tready  = grant_q & {N_IN{!m_axis_out_tfull}};
            m_axis_out_tdata  = sel_data;
            m_axis_out_tuser  = sel_user;
            // The beat that hits the length limit closes the packet downstream.
            m_axis_out_tlast  = sel_last | (beat_cnt_q == LAST_BEAT);
            m_axis_out_tvalid = sel_valid & !m_axis_out_tfull;
            xfer              = sel_valid & !m_axis_out_tfull;
         end
         ST_DRAIN: begin
            s_axis_in_tready = grant_q;
            xfer             = sel_valid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_INIT;
         gidx_q       <= '0;
         beat_cnt_q   <= '0;
         pkt_cnt_q    <= '0;
         overlen_q    <= 1'b0;
      end else begin
         overlen_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|s_axis_in_tvalid) begin
                  grant_q      <= rr_grant;
                  last_grant_q <= rr_grant;
                  gidx_q       <= rr_idx;
                  state_q      <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (xfer) begin
                  if (sel_last) begin
                     state_q    <= ST_IDLE;
                     beat_cnt_q <= '0;
                     pkt_cnt_q  <= pkt_cnt_q + 32'd1;
                  end else if (beat_cnt_q == LAST_BEAT) begin
                     state_q    <= ST_DRAIN;
                     beat_cnt_q <= '0;
                     pkt_cnt_q  <= pkt_cnt_q + 32'd1;
                     overlen_q  <= 1'b1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + CW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (xfer && sel_last) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant_o   = (state_q != ST_IDLE) ? grant_q : '0;
   assign busy_o    = (state_q != ST_IDLE);
   assign overlen_o = overlen_q;
   assign pkt_cnt_o = pkt_cnt_q;
   assign state_o   = state_q;

endmodule
